// File: rtl/frame_buffer_scheduler_if.sv
// Control/status bundle between the frame-buffer scheduler and the AXI writer/reader glue.
// The master side drives the event pulses; the slave side (the scheduler) returns addresses and status.
interface frame_buffer_scheduler_if #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int CNT_WIDTH      = 16
);
  logic                      enable;
  logic                      wr_frame_done;
  logic                      rd_frame_start;
  logic                      clr_cnt;
  logic [AXI_ADDR_WIDTH-1:0] wr_base_addr;
  logic [AXI_ADDR_WIDTH-1:0] rd_base_addr;
  logic                      rd_frame_valid;
  logic                      fresh;
  logic [1:0]                wr_idx;
  logic [1:0]                rd_idx;
  logic [CNT_WIDTH-1:0]      drop_cnt;
  logic [CNT_WIDTH-1:0]      repeat_cnt;
  logic [1:0]                state;

  modport master (
    output enable, wr_frame_done, rd_frame_start, clr_cnt,
    input  wr_base_addr, rd_base_addr, rd_frame_valid, fresh,
           wr_idx, rd_idx, drop_cnt, repeat_cnt, state
  );

  modport slave (
    input  enable, wr_frame_done, rd_frame_start, clr_cnt,
    output wr_base_addr, rd_base_addr, rd_frame_valid, fresh,
           wr_idx, rd_idx, drop_cnt, repeat_cnt, state
  );
endinterface

// File: rtl/frame_buffer_scheduler.sv
// Triple-buffer ownership scheduler: rotates writer/reader/spare DDR frame regions on
// frame-done and frame-start events and counts dropped and repeated frames.
module frame_buffer_scheduler #(
  parameter int                        AXI_ADDR_WIDTH = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = AXI_ADDR_WIDTH'(32'h1000_0000),
  parameter logic [AXI_ADDR_WIDTH-1:0] FRAME_STRIDE   = AXI_ADDR_WIDTH'(32'h0010_0000),
  parameter int                        CNT_WIDTH      = 16
) (
  input  logic                      clk_100Mhz,
  input  logic                      rst_n,
  frame_buffer_scheduler_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_FIRST = 2'd1,
    S_RUN        = 2'd2
  } state_t;

  localparam logic [1:0] WR_RST = 2'd0;
  localparam logic [1:0] RD_RST = 2'd1;
  localparam logic [1:0] SP_RST = 2'd2;

  state_t                    state_q, state_d;
  logic [1:0]                wr_idx_q, wr_idx_d;
  logic [1:0]                rd_idx_q, rd_idx_d;
  logic [1:0]                spare_idx_q, spare_idx_d;
  logic                      fresh_q, fresh_d;
  logic                      rd_frame_valid_q, rd_frame_valid_d;
  logic [CNT_WIDTH-1:0]      drop_cnt_q, drop_cnt_d;
  logic [CNT_WIDTH-1:0]      repeat_cnt_q, repeat_cnt_d;
  logic [AXI_ADDR_WIDTH-1:0] wr_base_addr_q, wr_base_addr_d;
  logic [AXI_ADDR_WIDTH-1:0] rd_base_addr_q, rd_base_addr_d;
  logic                      drop_inc;
  logic                      repeat_inc;

  function automatic logic [AXI_ADDR_WIDTH-1:0] addr_of(input logic [1:0] idx);
    return BASE_ADDR + (AXI_ADDR_WIDTH'(idx) * FRAME_STRIDE);
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt);
    return (&cnt) ? cnt : cnt + CNT_WIDTH'(1);
  endfunction

  always_comb begin
    state_d          = state_q;
    wr_idx_d         = wr_idx_q;
    rd_idx_d         = rd_idx_q;
    spare_idx_d      = spare_idx_q;
    fresh_d          = fresh_q;
    rd_frame_valid_d = rd_frame_valid_q;
    drop_inc         = 1'b0;
    repeat_inc       = 1'b0;

    if (!bus.enable) begin
      state_d          = S_IDLE;
      wr_idx_d         = WR_RST;
      rd_idx_d         = RD_RST;
      spare_idx_d      = SP_RST;
      fresh_d          = 1'b0;
      rd_frame_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_WAIT_FIRST;

        // The reader has nothing to show yet, so frame starts are not repeats.
        S_WAIT_FIRST: begin
          if (bus.wr_frame_done) begin
            wr_idx_d    = spare_idx_q;
            spare_idx_d = wr_idx_q;
            fresh_d     = 1'b1;
            drop_inc    = fresh_q;
            state_d     = S_RUN;
          end
        end

        S_RUN: begin
          if (bus.wr_frame_done && bus.rd_frame_start) begin
            // Reader takes the frame just finished; any older spare frame is lost.
            rd_idx_d         = wr_idx_q;
            wr_idx_d         = spare_idx_q;
            spare_idx_d      = rd_idx_q;
            fresh_d          = 1'b0;
            rd_frame_valid_d = 1'b1;
            drop_inc         = fresh_q;
          end else if (bus.wr_frame_done) begin
            wr_idx_d    = spare_idx_q;
            spare_idx_d = wr_idx_q;
            fresh_d     = 1'b1;
            drop_inc    = fresh_q;
          end else if (bus.rd_frame_start) begin
            if (fresh_q) begin
              rd_idx_d         = spare_idx_q;
              spare_idx_d      = rd_idx_q;
              fresh_d          = 1'b0;
              rd_frame_valid_d = 1'b1;
            end else begin
              repeat_inc = rd_frame_valid_q;
            end
          end
        end

        default: state_d = S_IDLE;
      endcase
    end

    if (bus.clr_cnt) begin
      drop_cnt_d   = '0;
      repeat_cnt_d = '0;
    end else begin
      drop_cnt_d   = drop_inc   ? sat_inc(drop_cnt_q)   : drop_cnt_q;
      repeat_cnt_d = repeat_inc ? sat_inc(repeat_cnt_q) : repeat_cnt_q;
    end

    // Addresses track the next-state indices so they line up with the registered indices.
    wr_base_addr_d = addr_of(wr_idx_d);
    rd_base_addr_d = addr_of(rd_idx_d);
  end

  always_ff @(posedge clk_100Mhz) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      wr_idx_q         <= WR_RST;
      rd_idx_q         <= RD_RST;
      spare_idx_q      <= SP_RST;
      fresh_q          <= 1'b0;
      rd_frame_valid_q <= 1'b0;
      drop_cnt_q       <= '0;
      repeat_cnt_q     <= '0;
      wr_base_addr_q   <= addr_of(WR_RST);
      rd_base_addr_q   <= addr_of(RD_RST);
    end else begin
      state_q          <= state_d;
      wr_idx_q         <= wr_idx_d;
      rd_idx_q         <= rd_idx_d;
      spare_idx_q      <= spare_idx_d;
      fresh_q          <= fresh_d;
      rd_frame_valid_q <= rd_frame_valid_d;
      drop_cnt_q       <= drop_cnt_d;
      repeat_cnt_q     <= repeat_cnt_d;
      wr_base_addr_q   <= wr_base_addr_d;
      rd_base_addr_q   <= rd_base_addr_d;
    end
  end

  assign bus.state          = state_q;
  assign bus.wr_idx         = wr_idx_q;
  assign bus.rd_idx         = rd_idx_q;
  assign bus.fresh          = fresh_q;
  assign bus.rd_frame_valid = rd_frame_valid_q;
  assign bus.drop_cnt       = drop_cnt_q;
  assign bus.repeat_cnt     = repeat_cnt_q;
  assign bus.wr_base_addr   = wr_base_addr_q;
  assign bus.rd_base_addr   = rd_base_addr_q;

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Bench for frame_buffer_scheduler: directed scenarios then random event traffic,
// all compared against a buffer-ownership reference model.
module tb_frame_buffer_scheduler;
  localparam int AW    = 32;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;
  localparam logic [31:0] BASE   = 32'h1000_0000;
  localparam logic [31:0] STRIDE = 32'h0010_0000;

  logic clk_100Mhz;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   cyc;

  frame_buffer_scheduler_if #(.AXI_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  frame_buffer_scheduler #(
    .AXI_ADDR_WIDTH(AW),
    .BASE_ADDR(BASE),
    .FRAME_STRIDE(STRIDE),
    .CNT_WIDTH(CW)
  ) dut (
    .clk_100Mhz(clk_100Mhz),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial begin
    clk_100Mhz = 1'b0;
    forever #5 clk_100Mhz = ~clk_100Mhz;
  end

  // Reference model: who owns which buffer, plus the frame bookkeeping.
  int m_state, m_wr, m_rd, m_sp, m_fresh, m_valid, m_drop, m_rep;

  task automatic model_reset_owners();
    m_wr = 0; m_rd = 1; m_sp = 2; m_fresh = 0; m_valid = 0;
  endtask

  task automatic model_step(input bit r, input bit en, input bit wd, input bit rs, input bit clr);
    bit dropped, repeated;
    int t;
    dropped  = 0;
    repeated = 0;
    if (!r) begin
      m_state = 0; model_reset_owners(); m_drop = 0; m_rep = 0;
      return;
    end
    if (!en) begin
      m_state = 0; model_reset_owners();
    end else if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      if (wd) begin
        dropped = (m_fresh == 1);
        t = m_wr; m_wr = m_sp; m_sp = t;
        m_fresh = 1; m_state = 2;
      end
    end else begin
      if (wd && rs) begin
        dropped = (m_fresh == 1);
        t = m_rd; m_rd = m_wr; m_wr = m_sp; m_sp = t;
        m_fresh = 0; m_valid = 1;
      end else if (wd) begin
        dropped = (m_fresh == 1);
        t = m_wr; m_wr = m_sp; m_sp = t;
        m_fresh = 1;
      end else if (rs) begin
        if (m_fresh == 1) begin
          t = m_rd; m_rd = m_sp; m_sp = t;
          m_fresh = 0; m_valid = 1;
        end else begin
          repeated = (m_valid == 1);
        end
      end
    end
    if (clr) begin
      m_drop = 0; m_rep = 0;
    end else begin
      if (dropped  && m_drop < CMAX) m_drop++;
      if (repeated && m_rep  < CMAX) m_rep++;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic [31:0] exp_wr_addr, exp_rd_addr;
    exp_wr_addr = BASE + 32'(m_wr) * STRIDE;
    exp_rd_addr = BASE + 32'(m_rd) * STRIDE;
    chk("state",          64'(bus.state),          64'(m_state));
    chk("wr_idx",         64'(bus.wr_idx),         64'(m_wr));
    chk("rd_idx",         64'(bus.rd_idx),         64'(m_rd));
    chk("wr_base_addr",   64'(bus.wr_base_addr),   64'(exp_wr_addr));
    chk("rd_base_addr",   64'(bus.rd_base_addr),   64'(exp_rd_addr));
    chk("fresh",          64'(bus.fresh),          64'(m_fresh));
    chk("rd_frame_valid", 64'(bus.rd_frame_valid), 64'(m_valid));
    chk("drop_cnt",       64'(bus.drop_cnt),       64'(m_drop));
    chk("repeat_cnt",     64'(bus.repeat_cnt),     64'(m_rep));
    chk("perm", 64'((bus.wr_idx != bus.rd_idx) && (bus.wr_idx < 2'd3) && (bus.rd_idx < 2'd3)), 64'd1);
  endtask

  task automatic step(input bit r, input bit en, input bit wd, input bit rs, input bit clr);
    rst_n              = r;
    bus.enable         = en;
    bus.wr_frame_done  = wd;
    bus.rd_frame_start = rs;
    bus.clr_cnt        = clr;
    model_step(r, en, wd, rs, clr);
    @(posedge clk_100Mhz);
    @(negedge clk_100Mhz);
    cyc++;
    compare_all();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    m_drop   = 0;
    m_rep    = 0;

    // Reset, enable, first frame written then displayed.
    step(0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 1, 0);
    step(1, 1, 1, 0, 0);
    chk("first_wr_addr", 64'(bus.wr_base_addr), 64'h1020_0000);
    step(1, 1, 0, 1, 0);
    chk("first_rd_addr", 64'(bus.rd_base_addr), 64'h1000_0000);

    // Three writes without display: two drops.
    repeat (3) step(1, 1, 1, 0, 0);
    chk("drop_after_3", 64'(bus.drop_cnt), 64'd2);

    // Consume the fresh frame, then repeats, then clear racing a repeat.
    step(1, 1, 0, 1, 0);
    repeat (2) step(1, 1, 0, 1, 0);
    chk("repeat_after_2", 64'(bus.repeat_cnt), 64'd2);
    step(1, 1, 0, 1, 1);
    chk("repeat_cleared", 64'(bus.repeat_cnt), 64'd0);

    // Reach wr=2 rd=0 spare=1 fresh=1, then simultaneous events.
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 1, 0, 1, 0);
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 1, 0);
    chk("rotate_rd", 64'(bus.rd_idx), 64'd2);
    chk("rotate_wr", 64'(bus.wr_idx), 64'd1);

    // Enable drop keeps counters; reset mid-run clears them.
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    step(0, 1, 0, 0, 0);

    // Saturation of both counters.
    step(1, 1, 0, 0, 0);
    repeat (CMAX + 4) step(1, 1, 1, 0, 0);
    step(1, 1, 0, 1, 0);
    repeat (CMAX + 4) step(1, 1, 0, 1, 0);
    chk("drop_sat",   64'(bus.drop_cnt),   64'(CMAX));
    chk("repeat_sat", 64'(bus.repeat_cnt), 64'(CMAX));

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) != 0,
           $urandom_range(0, 29) != 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 39) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/frame_buffer_scheduler.md
Name: frame_buffer_scheduler

Overview:
- Triple-buffer address scheduler between the camera-side AXI4 writer and the display-side AXI4 reader. Both run in the clk_100Mhz domain.
- Owns three DDR frame regions and supplies FRAME_BASE_ADDR to the writer and the reader.
- Rotates buffer ownership on frame-completion and frame-start events. The writer never overwrites the buffer being displayed, and the reader always gets the newest complete frame.
- Counts dropped and repeated frames.

Parameters:
AXI_ADDR_WIDTH, 32, address width of base-address outputs
BASE_ADDR, 32'h1000_0000, DDR address of buffer 0
FRAME_STRIDE, 32'h0010_0000, byte distance between buffers (>= 640*480*2)
CNT_WIDTH, 16, width of drop/repeat counters

Ports:
clk_100Mhz  in  1  system/AXI clock
rst_n  in  1  synchronous reset, active-low
enable  in  1  scheduler run enable (level)
wr_frame_done  in  1  1-cycle pulse: writer finished last burst (BVALID/BREADY) of a frame
rd_frame_start  in  1  1-cycle pulse: reader is about to fetch a new frame (display vsync)
clr_cnt  in  1  1-cycle pulse: clear drop/repeat counters
wr_base_addr  out  AXI_ADDR_WIDTH  base address for the writer's next/current frame
rd_base_addr  out  AXI_ADDR_WIDTH  base address for the reader's current frame
rd_frame_valid  out  1  reader buffer holds a complete frame
fresh  out  1  spare buffer holds a complete, not-yet-displayed frame
wr_idx  out  2  buffer index owned by the writer
rd_idx  out  2  buffer index owned by the reader
drop_cnt  out  CNT_WIDTH  frames overwritten before being displayed (saturating)
repeat_cnt  out  CNT_WIDTH  rd_frame_start events with no fresh frame (saturating)
state  out  2  FSM state (debug)

Behaviour:
- Reset (rst_n=0 at a clk_100Mhz edge) sets the following; all outputs are registered:
  - state=S_IDLE
  - wr_idx=0, rd_idx=1, spare_idx=2 (internal)
  - fresh=0, rd_frame_valid=0, drop_cnt=0, repeat_cnt=0
  - wr_base_addr=BASE_ADDR, rd_base_addr=BASE_ADDR+FRAME_STRIDE
- Invariant: {wr_idx, rd_idx, spare_idx} is always a permutation of {0,1,2}.
- Address rule: addr = BASE_ADDR + idx*FRAME_STRIDE. Computed from the next-state index and registered, so an address reflects an event one cycle after the event edge. Result is truncated to AXI_ADDR_WIDTH.
- FSM states and transitions:
  - S_IDLE (0): events ignored. enable=1 -> S_WAIT_FIRST.
  - S_WAIT_FIRST (1): writer fills buffer 0.
    - rd_frame_start is ignored; repeat_cnt does not count.
    - First wr_frame_done applies the writer rule below -> S_RUN.
  - S_RUN (2): all rules below apply.
  - enable=0 in any state -> S_IDLE next cycle. Indices, fresh, rd_frame_valid and addresses return to their reset values. Counters hold.
- Writer rule (wr_frame_done only):
  - Swap wr_idx and spare_idx, then fresh<=1.
  - If fresh was already 1, drop_cnt+1.
- Reader rule (rd_frame_start only, S_RUN):
  - If fresh=1: swap rd_idx and spare_idx, fresh<=0, rd_frame_valid<=1.
  - Else: no swap, repeat_cnt+1 (only when rd_frame_valid=1).
- Simultaneous wr_frame_done and rd_frame_start in the same cycle (S_RUN):
  - Rotate: rd<=old wr, wr<=old spare, spare<=old rd.
  - fresh<=0, rd_frame_valid<=1.
  - If fresh was 1, drop_cnt+1 (the old spare frame is discarded).
- Same-cycle event in S_WAIT_FIRST: only the writer rule applies.
- Counters:
  - Saturate at all-ones; no wrap.
  - clr_cnt has priority over an increment in the same cycle and clears to 0.
- wr_base_addr changes only in the cycle after wr_frame_done or an enable drop. The writer latches it at its next frame start, so a mid-frame change cannot occur.
- rst_n low mid-frame: immediate return to reset values on that edge, regardless of enable.

Test Plan:
- Reset then enable=1 -> state=1, wr_base_addr=0x1000_0000, rd_base_addr=0x1010_0000, rd_frame_valid=0.
- wr_frame_done in S_WAIT_FIRST -> next cycle state=2, wr_idx=2, wr_base_addr=0x1020_0000, fresh=1. Then rd_frame_start -> rd_idx=0, rd_base_addr=0x1000_0000, rd_frame_valid=1, fresh=0.
- Three wr_frame_done pulses with no rd_frame_start after the first frame is displayed:
  - drop_cnt=2.
  - wr_idx alternates between the two non-rd buffers; rd_idx unchanged.
- Two rd_frame_start pulses with fresh=0 -> repeat_cnt=2, rd_base_addr unchanged. clr_cnt concurrent with a third repeat -> repeat_cnt=0.
- Simultaneous wr_frame_done and rd_frame_start with wr=2, rd=0, spare=1, fresh=1 -> rd=2, wr=1, spare=0, fresh=0, drop_cnt+1. Permutation check holds every cycle.
- enable dropped in S_RUN -> next cycle state=0 with reset index and address values, counters retained. rst_n=0 mid-run -> all outputs at reset values on that edge.
